uart_16550_rx_engine: RTL and testbench

Serial receive engine of the UART 16550: oversamples the synchronised serial input on the 16x baud tick, frames characters per the line-control settings, and pushes each character with its status flags into the Rx FIFO stage. It sits between the SIN pad and the Rx FIFO. Its push/data/error outputs drive the Rx FIFO's push, data, parity-error, framing-error and break inputs directly.

---
 rtl/uart_16550_rx_engine.sv | 178 +++++++++++++++++
 tb/tb_uart_16550_rx_engine.sv | 399 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_16550_rx_engine.sv
// uart_16550_rx_engine: 16x-oversampled serial receive framer that pushes characters and status into the Rx FIFO.
// Optional build macro UART_RX_MAJORITY_VOTE_EN: every bit decision is a 3-sample majority vote.
module uart_16550_rx_engine (
    input  logic       WBs_CLK_i,
    input  logic       WBs_RST_i,
    input  logic       SIN_i,
    input  logic       Baud_16x_Tick_i,
    input  logic [1:0] LCR_WLS_i,
    input  logic       LCR_PEN_i,
    input  logic       LCR_EPS_i,
    input  logic       LCR_Stick_i,
    output logic       Rx_FIFO_Push_o,
    output logic [7:0] Rx_FIFO_DAT_o,
    output logic       Rx_Parity_Error_o,
    output logic       Rx_Framing_Error_o,
    output logic       Rx_Break_Interrupt_o,
    output logic       Rx_Busy_o
);

    // state      | meaning
    // IDLE       | line idle, waiting for a 1->0 edge
    // START      | validating the start bit at mid-bit
    // DATA       | shifting in 5..8 data bits, LSB first
    // PARITY     | sampling the parity bit
    // STOP       | sampling the first stop bit, push
    // BREAK_WAIT | break pushed, waiting for the line to return high
    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        START      = 3'd1,
        DATA       = 3'd2,
        PARITY     = 3'd3,
        STOP       = 3'd4,
        BREAK_WAIT = 3'd5
    } state_t;

    state_t     state, state_nxt;
    logic       sin_meta, sin_sync, sin_prev;
    logic       sample;
    logic [3:0] tick_cnt;
    logic [2:0] bit_cnt;
    logic [7:0] shift_reg;
    logic [1:0] wls_lat;
    logic       pen_lat, eps_lat, stick_lat;
    logic       par_bit, par_err;
    logic       start_edge, mid_tick, bit_tick, last_bit, is_break, par_calc;
    logic       load_start, start_ok, shift_en, par_en, push_en;

    always_ff @(posedge WBs_CLK_i or posedge WBs_RST_i) begin
        if (WBs_RST_i) begin
            sin_meta <= 1'b1;
            sin_sync <= 1'b1;
            sin_prev <= 1'b1;
        end else begin
            sin_meta <= SIN_i;
            sin_sync <= sin_meta;
            sin_prev <= sin_sync;
        end
    end

`ifdef UART_RX_MAJORITY_VOTE_EN
    // The vote window is the two stored tick samples plus the current tick's sample.
    logic [1:0] hist;

    always_ff @(posedge WBs_CLK_i or posedge WBs_RST_i) begin
        if (WBs_RST_i)
            hist <= 2'b11;
        else if (Baud_16x_Tick_i)
            hist <= {hist[0], sin_sync};
    end

    assign sample = (hist[1] & hist[0]) | (hist[1] & sin_sync) | (hist[0] & sin_sync);
`else
    assign sample = sin_sync;
`endif

    assign start_edge = sin_prev & ~sin_sync;
    assign mid_tick   = Baud_16x_Tick_i & (tick_cnt == 4'd7);
    assign bit_tick   = Baud_16x_Tick_i & (tick_cnt == 4'd15);
    assign last_bit   = (bit_cnt == (3'd4 + {1'b0, wls_lat}));
    assign is_break   = (shift_reg == 8'h00) & ~(pen_lat & par_bit) & ~sample;
    assign par_calc   = stick_lat ? (sample != ~eps_lat)
                      : eps_lat   ? ((^shift_reg) ^ sample)
                      :            ~((^shift_reg) ^ sample);

    always_ff @(posedge WBs_CLK_i or posedge WBs_RST_i) begin
        if (WBs_RST_i)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:       if (start_edge) state_nxt = START;
            START:      if (mid_tick) state_nxt = sample ? IDLE : DATA;
            DATA:       if (bit_tick && last_bit) state_nxt = pen_lat ? PARITY : STOP;
            PARITY:     if (bit_tick) state_nxt = STOP;
            STOP:       if (bit_tick) state_nxt = is_break ? BREAK_WAIT : IDLE;
            BREAK_WAIT: if (Baud_16x_Tick_i && sin_sync) state_nxt = IDLE;
            default:    state_nxt = IDLE;
        endcase
    end

    always_comb begin
        Rx_Busy_o  = (state != IDLE);
        load_start = 1'b0;
        start_ok   = 1'b0;
        shift_en   = 1'b0;
        par_en     = 1'b0;
        push_en    = 1'b0;
        case (state)
            IDLE:    load_start = start_edge;
            START:   start_ok   = mid_tick & ~sample;
            DATA:    shift_en   = bit_tick;
            PARITY:  par_en     = bit_tick;
            STOP:    push_en    = bit_tick;
            default: ;
        endcase
    end

    // Clearing wins over a coincident tick, so the edge-cycle tick is never counted.
    always_ff @(posedge WBs_CLK_i or posedge WBs_RST_i) begin
        if (WBs_RST_i)
            tick_cnt <= 4'd0;
        else if (load_start || start_ok)
            tick_cnt <= 4'd0;
        else if (Baud_16x_Tick_i)
            tick_cnt <= tick_cnt + 4'd1;
    end

    always_ff @(posedge WBs_CLK_i or posedge WBs_RST_i) begin
        if (WBs_RST_i) begin
            bit_cnt   <= 3'd0;
            shift_reg <= 8'h00;
            wls_lat   <= 2'b00;
            pen_lat   <= 1'b0;
            eps_lat   <= 1'b0;
            stick_lat <= 1'b0;
            par_bit   <= 1'b0;
            par_err   <= 1'b0;
        end else if (load_start) begin
            bit_cnt   <= 3'd0;
            shift_reg <= 8'h00;
            wls_lat   <= LCR_WLS_i;
            pen_lat   <= LCR_PEN_i;
            eps_lat   <= LCR_EPS_i;
            stick_lat <= LCR_Stick_i;
            par_bit   <= 1'b0;
            par_err   <= 1'b0;
        end else if (shift_en) begin
            shift_reg[bit_cnt] <= sample;
            bit_cnt            <= bit_cnt + 3'd1;
        end else if (par_en) begin
            par_bit <= sample;
            par_err <= par_calc;
        end
    end

    always_ff @(posedge WBs_CLK_i or posedge WBs_RST_i) begin
        if (WBs_RST_i) begin
            Rx_FIFO_Push_o       <= 1'b0;
            Rx_FIFO_DAT_o        <= 8'h00;
            Rx_Parity_Error_o    <= 1'b0;
            Rx_Framing_Error_o   <= 1'b0;
            Rx_Break_Interrupt_o <= 1'b0;
        end else begin
            Rx_FIFO_Push_o <= push_en;
            if (push_en) begin
                Rx_FIFO_DAT_o        <= shift_reg;
                Rx_Parity_Error_o    <= par_err;
                Rx_Framing_Error_o   <= ~sample;
                Rx_Break_Interrupt_o <= is_break;
            end
        end
    end

endmodule

// File: tb/tb_uart_16550_rx_engine.sv
// tb_uart_16550_rx_engine: randomized frames on a 4-clock baud tick, checked against a frame-level model.
module tb_uart_16550_rx_engine;

    logic       clk = 1'b0;
    logic       rst, sin, tick;
    logic [1:0] wls;
    logic       pen, eps, stick;
    logic       push, pe, fe, brk, busy;
    logic [7:0] dat;

    int   vecs = 0;
    int   errs = 0;
    int   cyc  = 0;
    logic busy_mid;

    typedef struct {
        logic [7:0] dat;
        logic       pe;
        logic       fe;
        logic       brk;
        logic       busy;
        int         cyc;
    } push_rec_t;

    push_rec_t push_q[$];

    uart_16550_rx_engine dut (
        .WBs_CLK_i            (clk),
        .WBs_RST_i            (rst),
        .SIN_i                (sin),
        .Baud_16x_Tick_i      (tick),
        .LCR_WLS_i            (wls),
        .LCR_PEN_i            (pen),
        .LCR_EPS_i            (eps),
        .LCR_Stick_i          (stick),
        .Rx_FIFO_Push_o       (push),
        .Rx_FIFO_DAT_o        (dat),
        .Rx_Parity_Error_o    (pe),
        .Rx_Framing_Error_o   (fe),
        .Rx_Break_Interrupt_o (brk),
        .Rx_Busy_o            (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk)
        if (push === 1'b1) push_q.push_back('{dat, pe, fe, brk, busy, cyc});

    initial begin
        tick = 1'b0;
        forever begin
            repeat (3) @(negedge clk);
            tick = 1'b1;
            @(negedge clk);
            tick = 1'b0;
        end
    end

    // Expected {data, parity_error, framing_error, break} for one character.
    function automatic logic [10:0] model(input logic [1:0] w, input logic p_en, input logic e,
                                          input logic s, input logic [7:0] d, input logic par,
                                          input logic stop);
        int         n, ones;
        logic [7:0] dm;
        logic       p_err, brk_exp;
        n    = 5 + int'(w);
        dm   = d & 8'((1 << n) - 1);
        ones = $countones(dm) + int'(par);
        if (!p_en)   p_err = 1'b0;
        else if (s)  p_err = (par != !e);
        else if (e)  p_err = (ones % 2) == 1;
        else         p_err = (ones % 2) == 0;
        brk_exp = (dm == 8'h00) && (!p_en || !par) && !stop;
        return {dm, p_err, !stop, brk_exp};
    endfunction

    task automatic wait_tick();
        do @(posedge clk); while (tick !== 1'b1);
        #1;
    endtask

    task automatic idle(input int n);
        sin = 1'b1;
        repeat (n) wait_tick();
    endtask

    task automatic set_cfg(input logic [1:0] w, input logic p, input logic e, input logic s);
        wls = w; pen = p; eps = e; stick = s;
    endtask

    // Drives one frame tick-aligned; LCR is scrambled after the start bit to prove it was latched.
    task automatic send_frame(input logic [7:0] d, input int nbits, input logic use_par,
                              input logic par, input logic stop, input int stop_ticks,
                              output int edge_cyc);
        wait_tick();
        sin = 1'b0;
        edge_cyc = cyc;
        repeat (8) wait_tick();
        busy_mid = busy;
        repeat (8) wait_tick();
        {wls, pen, eps, stick} = 5'($urandom);
        for (int i = 0; i < nbits; i++) begin
            sin = d[i];
            repeat (16) wait_tick();
        end
        if (use_par) begin
            sin = par;
            repeat (16) wait_tick();
        end
        sin = stop;
        repeat (stop_ticks) wait_tick();
        sin = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1; sin = 1'b1;
        set_cfg(2'b00, 1'b0, 1'b0, 1'b0);
        repeat (4) @(negedge clk);
        vecs++; if (push !== 1'b0)  begin errs++; $display("FAIL reset_push: got %b want 0", push); end
        vecs++; if (dat !== 8'h00)  begin errs++; $display("FAIL reset_dat: got %h want 00", dat); end
        vecs++; if (pe !== 1'b0)    begin errs++; $display("FAIL reset_pe: got %b want 0", pe); end
        vecs++; if (fe !== 1'b0)    begin errs++; $display("FAIL reset_fe: got %b want 0", fe); end
        vecs++; if (brk !== 1'b0)   begin errs++; $display("FAIL reset_brk: got %b want 0", brk); end
        vecs++; if (busy !== 1'b0)  begin errs++; $display("FAIL reset_busy: got %b want 0", busy); end
        rst = 1'b0;
        idle(4);
    endtask

    task automatic test_8n1();
        logic [10:0] exp;
        int          e;
        set_cfg(2'b11, 1'b0, 1'b0, 1'b0);
        idle(4);
        push_q.delete();
        exp = model(2'b11, 1'b0, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b1);
        send_frame(8'hA5, 8, 1'b0, 1'b0, 1'b1, 16, e);
        idle(4);
        vecs++; if (busy_mid !== 1'b1) begin errs++; $display("FAIL 8n1_busy_mid: got %b want 1", busy_mid); end
        vecs++; if (push_q.size() !== 1) begin errs++; $display("FAIL 8n1_push_count: got %0d want 1", push_q.size()); end
        if (push_q.size() > 0) begin
            vecs++;
            if ({push_q[0].dat, push_q[0].pe, push_q[0].fe, push_q[0].brk} !== exp) begin
                errs++; $display("FAIL 8n1_fields: got %h want %h", {push_q[0].dat, push_q[0].pe, push_q[0].fe, push_q[0].brk}, exp);
            end
            vecs++;
            if (push_q[0].cyc - e !== 608) begin
                errs++; $display("FAIL 8n1_latency: got %0d want 608", push_q[0].cyc - e);
            end
            vecs++;
            if (push_q[0].busy !== 1'b0) begin
                errs++; $display("FAIL 8n1_busy_at_push: got %b want 0", push_q[0].busy);
            end
        end
    endtask

    task automatic test_7e1();
        logic [10:0] exp;
        int          e;
        for (int k = 0; k < 2; k++) begin
            logic par;
            par = (k == 0);
            set_cfg(2'b10, 1'b1, 1'b1, 1'b0);
            idle(4);
            push_q.delete();
            exp = model(2'b10, 1'b1, 1'b1, 1'b0, 8'h35, par, 1'b1);
            send_frame(8'h35, 7, 1'b1, par, 1'b1, 16, e);
            idle(4);
            vecs++;
            if (push_q.size() !== 1) begin
                errs++; $display("FAIL 7e1_push_count[%0d]: got %0d want 1", k, push_q.size());
            end else begin
                vecs++;
                if ({push_q[0].dat, push_q[0].pe, push_q[0].fe, push_q[0].brk} !== exp) begin
                    errs++; $display("FAIL 7e1_fields[%0d]: got %h want %h", k, {push_q[0].dat, push_q[0].pe, push_q[0].fe, push_q[0].brk}, exp);
                end
            end
        end
    endtask

    task automatic test_stick();
        logic [10:0] exp;
        int          e;
        set_cfg(2'b00, 1'b1, 1'b0, 1'b1);
        idle(4);
        push_q.delete();
        exp = model(2'b00, 1'b1, 1'b0, 1'b1, 8'h1F, 1'b1, 1'b0);
        send_frame(8'h1F, 5, 1'b1, 1'b1, 1'b0, 16, e);
        idle(4);
        vecs++;
        if (push_q.size() !== 1) begin
            errs++; $display("FAIL stick_push_count: got %0d want 1", push_q.size());
        end else begin
            vecs++;
            if ({push_q[0].dat, push_q[0].pe, push_q[0].fe, push_q[0].brk} !== exp) begin
                errs++; $display("FAIL stick_fields: got %h want %h", {push_q[0].dat, push_q[0].pe, push_q[0].fe, push_q[0].brk}, exp);
            end
        end
    endtask

    task automatic test_break();
        int e;
        set_cfg(2'b11, 1'b0, 1'b0, 1'b0);
        idle(4);
        push_q.delete();
        wait_tick();
        sin = 1'b0;
        repeat (480) wait_tick();
        idle(40);
        vecs++;
        if (push_q.size() !== 1) begin
            errs++; $display("FAIL break_push_count: got %0d want 1", push_q.size());
        end else begin
            vecs++;
            if ({push_q[0].dat, push_q[0].pe, push_q[0].fe, push_q[0].brk} !== {8'h00, 1'b0, 1'b1, 1'b1}) begin
                errs++; $display("FAIL break_fields: got %h want %h", {push_q[0].dat, push_q[0].pe, push_q[0].fe, push_q[0].brk}, {8'h00, 3'b011});
            end
        end
        vecs++; if (busy !== 1'b0) begin errs++; $display("FAIL break_busy_after: got %b want 0", busy); end
        push_q.delete();
        set_cfg(2'b11, 1'b0, 1'b0, 1'b0);
        send_frame(8'h5A, 8, 1'b0, 1'b0, 1'b1, 16, e);
        idle(4);
        vecs++;
        if (push_q.size() !== 1 || push_q[0].dat !== 8'h5A || push_q[0].brk !== 1'b0) begin
            errs++; $display("FAIL break_next_char: got %0d pushes want one 5a", push_q.size());
        end
    endtask

    task automatic test_false_start();
        int   e;
        logic busy_glitch;
        set_cfg(2'b11, 1'b0, 1'b0, 1'b0);
        idle(4);
        push_q.delete();
        send_frame(8'hC3, 8, 1'b0, 1'b0, 1'b1, 16, e);
        idle(4);
        wait_tick();
        sin = 1'b0;
        repeat (5) wait_tick();
        sin = 1'b1;
        busy_glitch = busy;
        idle(40);
        vecs++; if (busy_glitch !== 1'b1) begin errs++; $display("FAIL false_start_busy_in_start: got %b want 1", busy_glitch); end
        vecs++; if (push_q.size() !== 1) begin errs++; $display("FAIL false_start_push_count: got %0d want 1", push_q.size()); end
        vecs++; if (busy !== 1'b0) begin errs++; $display("FAIL false_start_idle: got %b want 0", busy); end
        vecs++; if (dat !== 8'hC3) begin errs++; $display("FAIL false_start_dat_hold: got %h want c3", dat); end
    endtask

    task automatic test_reset_mid();
        logic [7:0] d;
        int         e;
        d = 8'h96;
        set_cfg(2'b11, 1'b0, 1'b0, 1'b0);
        idle(4);
        push_q.delete();
        wait_tick();
        sin = 1'b0;
        repeat (16) wait_tick();
        for (int i = 0; i < 4; i++) begin
            sin = d[i];
            repeat (16) wait_tick();
        end
        sin = d[4];
        repeat (8) wait_tick();
        #3 rst = 1'b1;
        #2;
        vecs++;
        if ({push, dat, pe, fe, brk, busy} !== 13'd0) begin
            errs++; $display("FAIL reset_mid_outputs: got %h want 0", {push, dat, pe, fe, brk, busy});
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        idle(20);
        vecs++; if (push_q.size() !== 0) begin errs++; $display("FAIL reset_mid_no_push: got %0d want 0", push_q.size()); end
        set_cfg(2'b11, 1'b0, 1'b0, 1'b0);
        send_frame(8'h3C, 8, 1'b0, 1'b0, 1'b1, 16, e);
        idle(4);
        vecs++;
        if (push_q.size() !== 1 || {push_q[0].dat, push_q[0].pe, push_q[0].fe, push_q[0].brk} !== {8'h3C, 3'b000}) begin
            errs++; $display("FAIL reset_mid_next_char: got %0d pushes want one 3c", push_q.size());
        end
    endtask

    task automatic test_glitch();
        logic [7:0] exp_dat;
`ifdef UART_RX_MAJORITY_VOTE_EN
        exp_dat = 8'h00;
`else
        exp_dat = 8'h04;
`endif
        set_cfg(2'b11, 1'b0, 1'b0, 1'b0);
        idle(4);
        push_q.delete();
        wait_tick();
        sin = 1'b0;
        repeat (48) wait_tick();
        repeat (7) wait_tick();
        sin = 1'b1;
        wait_tick();
        sin = 1'b0;
        repeat (8 + 5 * 16) wait_tick();
        sin = 1'b1;
        repeat (16) wait_tick();
        idle(4);
        vecs++;
        if (push_q.size() !== 1) begin
            errs++; $display("FAIL glitch_push_count: got %0d want 1", push_q.size());
        end else begin
            vecs++;
            if ({push_q[0].dat, push_q[0].pe, push_q[0].fe, push_q[0].brk} !== {exp_dat, 3'b000}) begin
                errs++; $display("FAIL glitch_fields: got %h want %h", {push_q[0].dat, push_q[0].pe, push_q[0].fe, push_q[0].brk}, {exp_dat, 3'b000});
            end
        end
    endtask

    task automatic test_random();
        logic [1:0]  w;
        logic        p, ev, s, par, st;
        logic [7:0]  d;
        logic [10:0] exp;
        int          e;
        for (int k = 0; k < 20; k++) begin
            w   = 2'($urandom);
            p   = 1'($urandom);
            ev  = 1'($urandom);
            s   = 1'($urandom);
            par = 1'($urandom);
            st  = ($urandom_range(0, 4) != 0);
            d   = 8'($urandom);
            set_cfg(w, p, ev, s);
            idle(3);
            push_q.delete();
            exp = model(w, p, ev, s, d, par, st);
            send_frame(d, 5 + int'(w), p, par, st, 16, e);
            idle(3);
            vecs++;
            if (push_q.size() !== 1) begin
                errs++; $display("FAIL random_push_count[%0d]: got %0d want 1", k, push_q.size());
            end else begin
                vecs++;
                if ({push_q[0].dat, push_q[0].pe, push_q[0].fe, push_q[0].brk} !== exp) begin
                    errs++; $display("FAIL random_fields[%0d]: got %h want %h (wls=%0d pen=%b eps=%b stick=%b d=%h par=%b stop=%b)",
                                     k, {push_q[0].dat, push_q[0].pe, push_q[0].fe, push_q[0].brk}, exp, w, p, ev, s, d, par, st);
                end
            end
        end
    endtask

    // Stop bit held only to its mid-point before the next start: the tightest legal spacing.
    task automatic test_back_to_back();
        logic [7:0] d[6];
        int         e;
        set_cfg(2'b00, 1'b0, 1'b0, 1'b0);
        idle(4);
        push_q.delete();
        for (int k = 0; k < 6; k++) begin
            d[k] = 8'($urandom);
            set_cfg(2'b00, 1'b0, 1'b0, 1'b0);
            send_frame(d[k], 5, 1'b0, 1'b0, 1'b1, 7, e);
        end
        idle(8);
        vecs++;
        if (push_q.size() !== 6) begin
            errs++; $display("FAIL b2b_push_count: got %0d want 6", push_q.size());
        end else begin
            for (int k = 0; k < 6; k++) begin
                vecs++;
                if ({push_q[k].dat, push_q[k].pe, push_q[k].fe, push_q[k].brk} !== model(2'b00, 1'b0, 1'b0, 1'b0, d[k], 1'b0, 1'b1)) begin
                    errs++; $display("FAIL b2b_fields[%0d]: got %h want %h", k, {push_q[k].dat, push_q[k].pe, push_q[k].fe, push_q[k].brk},
                                     model(2'b00, 1'b0, 1'b0, 1'b0, d[k], 1'b0, 1'b1));
                end
                if (k > 0) begin
                    vecs++;
                    if (push_q[k].cyc - push_q[k-1].cyc !== 416) begin
                        errs++; $display("FAIL b2b_spacing[%0d]: got %0d want 416", k, push_q[k].cyc - push_q[k-1].cyc);
                    end
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_8n1();
        test_7e1();
        test_stick();
        test_break();
        test_false_start();
        test_reset_mid();
        test_glitch();
        test_random();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
